serializer_fifo_wn: RTL and testbench

//  Parametrised wide-to-narrow serializer with an input word FIFO; successor to the fixed 64->8 converter.

---
 rtl/serializer_fifo_wn.sv | 167 ++++++++++++++++
 tb/tb_serializer_fifo_wn.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_fifo_wn.sv
// Wide-to-narrow serializer: IN_W-bit word FIFO feeding a shift register that emits OUT_W-bit chunks.
// Optional overflow status ports are enabled with `SER_OVF_STATUS_EN.
module serializer_fifo_wn #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     strobe_in,
    input  logic [IN_W-1:0]          input_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     req_data,
    output logic                     ready,
    output logic                     strobe_out,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_end
`ifdef SER_OVF_STATUS_EN
    ,
    input  logic                     clr_ovf,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int NCHUNK = IN_W / OUT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(NCHUNK);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic [IN_W-1:0]  sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             strobe_q;
    logic [OUT_W-1:0] data_q;
    logic             end_q;

    logic             full_s, grant_s, last_s, push_s, pop_s;
    logic [OUT_W-1:0] chunk_s;
    logic [IN_W-1:0]  shifted_s;

    assign full_s  = (level_q == (AW+1)'(DEPTH));
    assign grant_s = req_data && (state_q == ST_SHIFT);
    assign last_s  = grant_s && (cnt_q == CW'(NCHUNK - 1));
    assign push_s  = strobe_in && !full_s;
    // A pop either fills an idle shift register or refills it on the last chunk, so words stream bubble-free.
    assign pop_s   = (level_q != '0) && ((state_q == ST_EMPTY) || last_s);

    // Chunk selection and shift direction.
    always_comb begin
        chunk_s   = '0;
        shifted_s = sr_q;
        if (MSB_FIRST != 0) begin
            chunk_s   = sr_q[IN_W-1 -: OUT_W];
            shifted_s = sr_q << OUT_W;
        end else begin
            chunk_s   = sr_q[OUT_W-1:0];
            shifted_s = sr_q >> OUT_W;
        end
    end

    // Next-state logic for the FSM, shift register, chunk counter and fill level.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_EMPTY: begin
                if (pop_s) state_d = ST_SHIFT;
                else       state_d = ST_EMPTY;
            end
            ST_SHIFT: begin
                if (last_s && !pop_s) state_d = ST_EMPTY;
                else                  state_d = ST_SHIFT;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (pop_s) begin
            sr_d  = mem_q[rd_ptr_q];
            cnt_d = '0;
        end else if (grant_s) begin
            sr_d  = shifted_s;
            cnt_d = cnt_q + CW'(1);
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Word storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= input_data;
    end

    // Pointers, FSM, shift register and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            state_q  <= ST_EMPTY;
            strobe_q <= 1'b0;
            data_q   <= '0;
            end_q    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q  <= level_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            strobe_q <= grant_s;
            end_q    <= last_s;
            if (grant_s) data_q <= chunk_s;
        end
    end

    assign full       = full_s;
    assign level      = level_q;
    assign ready      = (state_q == ST_SHIFT);
    assign strobe_out = strobe_q;
    assign data_out   = data_q;
    assign data_end   = end_q;

`ifdef SER_OVF_STATUS_EN
    logic        ovf_q;
    logic [15:0] drop_q;
    logic        drop_s;

    assign drop_s = strobe_in && full_s;

    // Sticky overflow flag and saturating drop counter; clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            drop_q <= 16'h0000;
        end else if (clr_ovf) begin
            ovf_q  <= 1'b0;
            drop_q <= 16'h0000;
        end else if (drop_s) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'h0001;
        end
    end

    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_serializer_fifo_wn.sv
// Directed bench for serializer_fifo_wn: an MSB-first and an LSB-first instance share all inputs.
module tb_serializer_fifo_wn;

    logic        clk = 1'b0;
    logic        reset_n, strobe_in, req_data;
    logic [63:0] input_data;
    logic        full_m, ready_m, strobe_out_m, data_end_m;
    logic [4:0]  level_m;
    logic [7:0]  data_out_m;
    logic        full_l, ready_l, strobe_out_l, data_end_l;
    logic [4:0]  level_l;
    logic [7:0]  data_out_l;
`ifdef SER_OVF_STATUS_EN
    logic        clr_ovf;
    logic        ovf_m, ovf_l;
    logic [15:0] dc_m, dc_l;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic       prev_grant = 1'b0;
    logic [8:0] got_m[$];
    logic [8:0] got_l[$];
    int         got_cyc[$];

    always #5 clk = ~clk;

    serializer_fifo_wn #(.IN_W(64), .OUT_W(8), .DEPTH(16), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in), .input_data(input_data),
        .full(full_m), .level(level_m), .req_data(req_data), .ready(ready_m),
        .strobe_out(strobe_out_m), .data_out(data_out_m), .data_end(data_end_m)
`ifdef SER_OVF_STATUS_EN
        , .clr_ovf(clr_ovf), .overflow(ovf_m), .drop_cnt(dc_m)
`endif
    );

    serializer_fifo_wn #(.IN_W(64), .OUT_W(8), .DEPTH(16), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in), .input_data(input_data),
        .full(full_l), .level(level_l), .req_data(req_data), .ready(ready_l),
        .strobe_out(strobe_out_l), .data_out(data_out_l), .data_end(data_end_l)
`ifdef SER_OVF_STATUS_EN
        , .clr_ovf(clr_ovf), .overflow(ovf_l), .drop_cnt(dc_l)
`endif
    );

    typedef struct {
        logic [63:0] word;
        logic [63:0] lsb_stream;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] w);
        strobe_in  = 1'b1;
        input_data = w;
        tick();
        strobe_in  = 1'b0;
    endtask

    task automatic wait_chunks(input int n, input int budget);
        int k = 0;
        while (got_m.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("chunk_budget", 64'(got_m.size() >= n), 64'd1);
    endtask

    function automatic logic [63:0] wf(input int i);
        return {8'(i), 48'h0102_0304_0506, 8'(255 - i)};
    endfunction

    // strobe_out must follow exactly one cycle after a sampled grant (req_data && ready).
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_grant = 1'b0;
        end else begin
            chk("strobe_vs_grant", 64'(strobe_out_m), 64'(prev_grant));
            if (strobe_out_m) begin
                got_m.push_back({data_end_m, data_out_m});
                got_cyc.push_back(cyc);
            end
            if (strobe_out_l) got_l.push_back({data_end_l, data_out_l});
            prev_grant = req_data && ready_m;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        logic        r;
        int          ends;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'hEFCD_AB89_6745_2301};
        vecs[1] = '{64'hFF00_AA55_0F0F_8001, 64'h0180_0F0F_55AA_00FF};
        vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 64'h0DF0_FECA_EFBE_ADDE};
        vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

        reset_n = 1'b0; strobe_in = 1'b0; req_data = 1'b0; input_data = 64'd0;
`ifdef SER_OVF_STATUS_EN
        clr_ovf = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_full", 64'(full_m), 64'd0);
        chk("rst_level", 64'(level_m), 64'd0);
        chk("rst_ready", 64'(ready_m), 64'd0);
        chk("rst_strobe", 64'(strobe_out_m), 64'd0);
        chk("rst_data", 64'(data_out_m), 64'd0);
        chk("rst_end", 64'(data_end_m), 64'd0);
        chk("rst_ready_lsb", 64'(ready_l), 64'd0);
`ifdef SER_OVF_STATUS_EN
        chk("rst_ovf", 64'(ovf_m), 64'd0);
        chk("rst_dropcnt", 64'(dc_m), 64'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // Single words in both chunk orders, req_data held high from the write onward.
        for (int v = 0; v < 4; v++) begin
            got_m.delete(); got_l.delete(); got_cyc.delete();
            strobe_in = 1'b1; input_data = vecs[v].word; req_data = 1'b1;
            tick();
            strobe_in = 1'b0;
            if (v == 0) begin
                @(negedge clk);
                chk("lat_level_n", 64'(level_m), 64'd1);
                chk("lat_ready_n", 64'(ready_m), 64'd0);
                @(negedge clk);
                chk("lat_level_n1", 64'(level_m), 64'd0);
                chk("lat_ready_n1", 64'(ready_m), 64'd1);
                tick();
            end
            wait_chunks(8, 20);
            tick(); tick();
            req_data = 1'b0;
            chk("vec_count", 64'(got_m.size()), 64'd8);
            chk("vec_count_lsb", 64'(got_l.size()), 64'd8);
            chk("vec_contig", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
            for (int k = 0; k < 8; k++) begin
                chk("msb_chunk", 64'(got_m[k]), 64'({1'(k == 7), vecs[v].word[63-8*k -: 8]}));
                chk("lsb_chunk", 64'(got_l[k]), 64'({1'(k == 7), vecs[v].lsb_stream[63-8*k -: 8]}));
            end
            @(negedge clk);
            chk("vec_ready_drop", 64'(ready_m), 64'd0);
            tick();
        end

        // Fill: the first word moves into the shift register, so 17 writes reach level 16.
        got_m.delete(); got_cyc.delete();
        for (int i = 0; i < 17; i++) write_word(wf(i));
        @(negedge clk);
        chk("fill_level", 64'(level_m), 64'd16);
        chk("fill_full", 64'(full_m), 64'd1);
        chk("fill_level_lsb", 64'(level_l), 64'd16);
        tick();
        write_word(64'hBAD0_BAD0_BAD0_BAD0);
        @(negedge clk);
        chk("drop_level", 64'(level_m), 64'd16);
`ifdef SER_OVF_STATUS_EN
        chk("drop_ovf", 64'(ovf_m), 64'd1);
        chk("drop_cnt", 64'(dc_m), 64'd1);
        chk("drop_ovf_lsb", 64'(ovf_l), 64'd1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_ovf", 64'(ovf_m), 64'd0);
        chk("clr_cnt", 64'(dc_m), 64'd0);
`endif
        tick();
        req_data = 1'b1;
        wait_chunks(136, 200);
        tick(); tick();
        req_data = 1'b0;
        chk("fill_count", 64'(got_m.size()), 64'd136);
        chk("fill_contig", 64'(got_cyc[135] - got_cyc[0]), 64'd135);
        ends = 0;
        for (int i = 0; i < 17; i++) begin
            w = wf(i);
            for (int k = 0; k < 8; k++) begin
                chk("fill_chunk", 64'(got_m[8*i+k]), 64'({1'(k == 7), w[63-8*k -: 8]}));
                if (got_m[8*i+k][8]) ends++;
            end
        end
        chk("fill_ends", 64'(ends), 64'd17);
        @(negedge clk);
        chk("fill_level_end", 64'(level_m), 64'd0);
        chk("fill_full_end", 64'(full_m), 64'd0);
        tick();

        // Consumer drives req_data from ready delayed by one cycle.
        got_m.delete(); got_cyc.delete();
        for (int i = 20; i < 23; i++) write_word(wf(i));
        for (int c = 0; c < 100 && got_m.size() < 24; c++) begin
            @(negedge clk);
            r = ready_m;
            @(posedge clk);
            #1;
            req_data = r;
        end
        tick(); tick();
        req_data = 1'b0;
        chk("lag_count", 64'(got_m.size()), 64'd24);
        for (int i = 0; i < 3; i++) begin
            w = wf(20 + i);
            for (int k = 0; k < 8; k++)
                chk("lag_chunk", 64'(got_m[8*i+k]), 64'({1'(k == 7), w[63-8*k -: 8]}));
        end
        tick();

        // Streaming: a write every 8th cycle with req_data high leaves no bubble.
        got_m.delete(); got_cyc.delete();
        req_data = 1'b1;
        for (int c = 0; c < 48; c++) begin
            strobe_in  = ((c % 8) == 0) && (c < 32);
            input_data = wf(30 + c / 8);
            tick();
            chk("stream_level", 64'(level_m <= 5'd1), 64'd1);
        end
        strobe_in = 1'b0;
        req_data  = 1'b0;
        chk("stream_count", 64'(got_m.size()), 64'd32);
        chk("stream_contig", 64'(got_cyc[31] - got_cyc[0]), 64'd31);
        for (int i = 0; i < 4; i++) begin
            w = wf(30 + i);
            for (int k = 0; k < 8; k++)
                chk("stream_chunk", 64'(got_m[8*i+k]), 64'({1'(k == 7), w[63-8*k -: 8]}));
        end
        tick();

        // Reset mid-word with two words still buffered.
        got_m.delete(); got_cyc.delete();
        for (int i = 40; i < 43; i++) write_word(wf(i));
        chk("mid_level", 64'(level_m), 64'd2);
        req_data = 1'b1;
        wait_chunks(3, 20);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe", 64'(strobe_out_m), 64'd0);
        chk("mid_rst_data", 64'(data_out_m), 64'd0);
        chk("mid_rst_end", 64'(data_end_m), 64'd0);
        chk("mid_rst_ready", 64'(ready_m), 64'd0);
        chk("mid_rst_level", 64'(level_m), 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        got_m.delete();
        repeat (10) tick();
        chk("post_rst_strobes", 64'(got_m.size()), 64'd0);
        chk("post_rst_ready", 64'(ready_m), 64'd0);
        chk("post_rst_level", 64'(level_m), 64'd0);
        write_word(vecs[0].word);
        wait_chunks(8, 20);
        chk("post_rst_first", 64'(got_m[0]), 64'h001);
        chk("post_rst_last", 64'(got_m[7]), 64'h1EF);
        req_data = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
